// File: rtl/cart_rom_responder.sv
// Cartridge header bus responder: synchronizes the asynchronous header pins,
// waits for the address/select word to settle, fetches from a 1-cycle ROM and drives the byte back.
module cart_rom_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        enable,
  input  logic [13:0] cart_addr,
  input  logic        cart_s4,
  input  logic        cart_s5,
  input  logic        cart_phi,
  output logic [7:0]  cart_data,
  output logic        cart_data_oe,
  output logic [14:0] rom_addr,
  output logic        rom_en,
  input  logic [7:0]  rom_data,
  output logic [15:0] access_cnt,
  output logic        err_overlap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FETCH,
    S_WAIT,
    S_DRIVE
  } state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYC);

  // Bit layout of every synchronizer stage: {phi, s4, s5, addr[13:0]}
  logic [16:0] sync_q [SYNC_STAGES];
  logic [16:0] sync_d [SYNC_STAGES];

  logic [15:0] w_cur;
  logic [15:0] w_next;
  logic        sel4;
  logic        sel5;
  logic        one_sel;
  logic        both_sel;
  logic        phi_rise;

  logic [3:0]  stab_q, stab_d;
  state_t      state_q, state_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [15:0] lat_w_q, lat_w_d;
  logic [7:0]  cart_data_q, cart_data_d;
  logic [15:0] acc_q, acc_d;
  logic        err_q, err_d;

  always_comb begin
    sync_d[0] = {cart_phi, cart_s4, cart_s5, cart_addr};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign w_cur    = sync_q[SYNC_STAGES-1][15:0];
  assign w_next   = sync_q[SYNC_STAGES-2][15:0];
  assign sel4     = w_cur[15];
  assign sel5     = w_cur[14];
  assign one_sel  = sel4 ^ sel5;
  assign both_sel = sel4 & sel5;
  assign phi_rise = sync_q[SYNC_STAGES-2][16] & ~sync_q[SYNC_STAGES-1][16];

  // Count tracks the word arriving at the synchronizer output, so it already
  // reads 1 in the first cycle a new word is visible.
  always_comb begin
    if (w_next != w_cur) begin
      stab_d = 4'd1;
    end else if (stab_q >= STABLE_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 4'd1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (phi_rise && one_sel && (acc_q != '1)) begin
      acc_d = acc_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    lat_w_d     = lat_w_q;
    cart_data_d = cart_data_q;
    err_d       = err_q | both_sel;

    if (!enable || both_sel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (one_sel) state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (!one_sel) begin
            state_d = S_IDLE;
          end else if (stab_q >= STABLE_MAX) begin
            state_d    = S_FETCH;
            rom_addr_d = {sel5, w_cur[13:0]};
            lat_w_d    = w_cur;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          state_d     = S_DRIVE;
          cart_data_d = rom_data;
        end
        S_DRIVE: begin
          if (!one_sel) begin
            state_d = S_IDLE;
          end else if (w_cur != lat_w_q) begin
            state_d = S_SETTLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      stab_q      <= '0;
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      lat_w_q     <= '0;
      cart_data_q <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      stab_q      <= stab_d;
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      lat_w_q     <= lat_w_d;
      cart_data_q <= cart_data_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
    end
  end

  assign cart_data    = cart_data_q;
  assign cart_data_oe = (state_q == S_DRIVE);
  assign rom_en       = (state_q == S_FETCH);
  assign rom_addr     = rom_addr_q;
  assign access_cnt   = acc_q;
  assign err_overlap  = err_q;

endmodule

// File: tb/tb_cart_rom_responder.sv
// Bench for cart_rom_responder: directed plan steps plus randomized reads
// checked against a ROM array and the pin-to-drive latency rule.
module tb_cart_rom_responder;
  localparam int SYNC = 2;
  localparam int STAB = 2;
  localparam int LAT  = SYNC + STAB + 2;

  logic        clk = 1'b0;
  logic        rst_L = 1'b1;
  logic        enable = 1'b0;
  logic [13:0] cart_addr = '0;
  logic        cart_s4 = 1'b0;
  logic        cart_s5 = 1'b0;
  logic        cart_phi = 1'b0;
  logic [7:0]  cart_data;
  logic        cart_data_oe;
  logic [14:0] rom_addr;
  logic        rom_en;
  logic [7:0]  rom_data = '0;
  logic [15:0] access_cnt;
  logic        err_overlap;

  logic [7:0]  rom_mem [32768];
  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int b2b = 0;
  int wrong_byte = 0;
  logic prev_en = 1'b0;
  logic [13:0] cur_a = '0;
  logic cur_s4 = 1'b0;
  logic cur_s5 = 1'b0;

  cart_rom_responder #(.SYNC_STAGES(SYNC), .STABLE_CYC(STAB)) dut (
    .clk(clk), .rst_L(rst_L), .enable(enable),
    .cart_addr(cart_addr), .cart_s4(cart_s4), .cart_s5(cart_s5), .cart_phi(cart_phi),
    .cart_data(cart_data), .cart_data_oe(cart_data_oe),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .access_cnt(access_cnt), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  always @(negedge clk) begin
    if (rom_en) en_cnt++;
    if (rom_en && prev_en) b2b++;
    prev_en = rom_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic [13:0] a, input logic s4, input logic s5);
    cart_addr = a; cart_s4 = s4; cart_s5 = s5;
    cur_a = a; cur_s4 = s4; cur_s5 = s5;
  endtask

  task automatic phi_pulse();
    cart_phi = 1'b1; step(); step();
    cart_phi = 1'b0; step(); step();
  endtask

  // Pins were just changed; expect oe (after any drop) LAT edges later with the ROM byte.
  task automatic wait_drive(input string tag, input logic [14:0] exp_addr);
    int n;
    int start_en;
    bit seen_low;
    start_en = en_cnt;
    seen_low = !cart_data_oe;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (!cart_data_oe) seen_low = 1'b1;
      else if (seen_low) break;
    end
    if (seen_low && cart_data_oe && cart_data !== rom_mem[exp_addr]) wrong_byte++;
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_data"}, 32'(cart_data), 32'(rom_mem[exp_addr]));
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'(exp_addr));
    check({tag, "_rom_en_pulses"}, 32'(en_cnt - start_en), 32'd1);
  endtask

  initial begin
    logic [13:0] ra;
    logic        win;
    for (int i = 0; i < 32768; i++) rom_mem[i] = 8'($urandom);
    rom_mem[15'h0123] = 8'hA5;
    rom_mem[15'h4123] = 8'h3C;
    rom_mem[15'h0010] = 8'h11;
    rom_mem[15'h0011] = 8'h22;

    #2 rst_L = 1'b0;
    #1;
    check("rst_cart_data", 32'(cart_data), 32'h0);
    check("rst_oe", 32'(cart_data_oe), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_rom_en", 32'(rom_en), 32'h0);
    check("rst_access_cnt", 32'(access_cnt), 32'h0);
    check("rst_err", 32'(err_overlap), 32'h0);
    step(); step();
    rst_L = 1'b1;
    enable = 1'b1;
    step(); step(); step();

    set_pins(14'h0123, 1'b1, 1'b0);
    wait_drive("s4_read", 15'h0123);
    check("s4_byte", 32'(cart_data), 32'hA5);
    check("s4_oe", 32'(cart_data_oe), 32'h1);

    set_pins(14'h0123, 1'b0, 1'b0);
    step(); step();
    check("exit_oe_still_high", 32'(cart_data_oe), 32'h1);
    step();
    check("exit_oe_low", 32'(cart_data_oe), 32'h0);

    set_pins(14'h0123, 1'b0, 1'b1);
    wait_drive("s5_read", 15'h4123);
    check("s5_byte", 32'(cart_data), 32'h3C);

    set_pins(14'h0010, 1'b1, 1'b0);
    wait_drive("b2b_first", 15'h0010);
    check("b2b_first_byte", 32'(cart_data), 32'h11);
    set_pins(14'h0011, 1'b1, 1'b0);
    wait_drive("b2b_second", 15'h0011);
    check("b2b_second_byte", 32'(cart_data), 32'h22);

    enable = 1'b0;
    step();
    check("enable_drop_oe", 32'(cart_data_oe), 32'h0);
    set_pins(14'h0011, 1'b0, 1'b0);
    step(); step(); step(); step();
    enable = 1'b1;
    step(); step();
    check("reenable_idle_oe", 32'(cart_data_oe), 32'h0);

    set_pins(14'h0200, 1'b1, 1'b0);
    step();
    set_pins(14'h03FF, 1'b1, 1'b0);
    step();
    set_pins(14'h0200, 1'b1, 1'b0);
    wait_drive("glitch", 15'h0200);

    set_pins(14'h0200, 1'b0, 1'b0);
    step(); step(); step(); step();
    set_pins(14'h0200, 1'b1, 1'b1);
    step();
    check("overlap_oe_1", 32'(cart_data_oe), 32'h0);
    step(); step();
    check("overlap_oe_3", 32'(cart_data_oe), 32'h0);
    check("overlap_err", 32'(err_overlap), 32'h1);
    set_pins(14'h0250, 1'b1, 1'b0);
    wait_drive("after_overlap", 15'h0250);
    check("overlap_err_sticky", 32'(err_overlap), 32'h1);

    for (int i = 0; i < 24; i++) begin
      ra  = 14'($urandom_range(0, 16383));
      win = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        set_pins(cur_a, 1'b0, 1'b0);
        step(); step(); step(); step();
        check("rand_idle_oe", 32'(cart_data_oe), 32'h0);
      end
      if (ra == cur_a && win == cur_s5 && (cur_s4 | cur_s5)) ra = ra ^ 14'h1;
      set_pins(ra, ~win, win);
      wait_drive("rand_read", {win, ra});
    end

    check("b2b_wrong_byte", 32'(wrong_byte), 32'h0);

    set_pins(14'h0321, 1'b1, 1'b0);
    wait_drive("cnt_read", 15'h0321);
    check("cnt_start", 32'(access_cnt), 32'h0);
    for (int i = 0; i < 5; i++) phi_pulse();
    step(); step();
    check("cnt_five", 32'(access_cnt), 32'd5);
    set_pins(14'h0321, 1'b0, 1'b0);
    step(); step(); step(); step();
    for (int i = 0; i < 3; i++) phi_pulse();
    step(); step();
    check("cnt_no_select", 32'(access_cnt), 32'd5);

    set_pins(14'h0321, 1'b1, 1'b0);
    wait_drive("pre_reset_read", 15'h0321);
    #2 rst_L = 1'b0;
    #1;
    check("reset_oe_async", 32'(cart_data_oe), 32'h0);
    check("reset_cart_data", 32'(cart_data), 32'h0);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    check("reset_rom_en", 32'(rom_en), 32'h0);
    check("reset_access_cnt", 32'(access_cnt), 32'h0);
    check("reset_err", 32'(err_overlap), 32'h0);
    step(); step();
    check("reset_held_oe", 32'(cart_data_oe), 32'h0);
    rst_L = 1'b1;
    wait_drive("post_reset_read", 15'h0321);

    check("rom_en_back_to_back", 32'(b2b), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cart_rom_responder.md
# cart_rom_responder

Cartridge-side responder for the CPU's cartridge header bus: the CPU board drives a 14-bit address, two window selects (S4 = $4000–$7FFF, S5 = $8000–$BFFF) and phi1 across the header. This block samples those asynchronous pins into its own clock domain, waits for them to settle, and fetches the byte from a 32 KB synchronous ROM with a 1-cycle read latency. It drives the byte back on the header data lines, with an output enable. It sits on the cartridge-emulation FPGA and is the responder for the host's cartridge read path.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of every input synchronizer (≥2)
- STABLE_CYC, 2, consecutive identical synchronized samples required before fetch (1–15)

Ports:
- clk  in  1  cartridge-FPGA clock (27 MHz nominal); only clock
- rst_L  in  1  reset, asynchronous, active-low
- enable  in  1  0 = never drive the bus; FSM is held in IDLE
- cart_addr  in  14  header address A13..A0 (asynchronous)
- cart_s4  in  1  window select $4000–$7FFF (asynchronous)
- cart_s5  in  1  window select $8000–$BFFF (asynchronous)
- cart_phi  in  1  host phi1 (asynchronous); used only for access counting
- cart_data  out  8  byte returned to host
- cart_data_oe  out  1  tri-state enable for cart_data pads
- rom_addr  out  15  ROM address {s5, addr[13:0]}
- rom_en  out  1  ROM read strobe
- rom_data  in  8  ROM output, valid 1 clk after rom_en
- access_cnt  out  16  phi1 rising edges seen with exactly one select active
- err_overlap  out  1  sticky: both selects were seen active together

## Operation
- All 17 header inputs pass through SYNC_STAGES flops. Only the synchronized copies are used.
- Candidate word W = {s4, s5, addr}. The stability counter resets to 1 whenever W differs from the previous cycle's W, and otherwise increments, saturating at STABLE_CYC.
- FSM states:
  - IDLE: oe=0. Go to SETTLE when enable=1 and exactly one select is active.
  - SETTLE: wait until the stability count reaches STABLE_CYC. Go to IDLE if the selects drop or both become active.
  - FETCH: latch rom_addr from W and assert rom_en for 1 cycle. Go to WAIT.
  - WAIT: register rom_data into cart_data at the end of this cycle. Go to DRIVE.
  - DRIVE: oe=1 and cart_data is held. Leave on either of two conditions:
    - W changes with one select still active: go to SETTLE; oe drops on the same edge.
    - No select active: go to IDLE with oe=0.
- Overlap: if s4 and s5 are both active in any state:
  - err_overlap is set.
  - The FSM goes to IDLE and oe=0.
  - The state is not left until at most one select is active.
  - err_overlap clears only on reset.
- enable falling in any state forces IDLE and oe=0 on the next edge.
- access_cnt increments by 1 on each synchronized rising edge of cart_phi (detected from the last two synchronizer flops) while exactly one select is active. It saturates at 16'hFFFF and does not wrap.
- Reset mid-access: all state is cleared immediately (asynchronously) and oe drops at once. No partial drive is allowed.

## Timing
Reset values:
- cart_data = 8'h00, cart_data_oe = 0, rom_addr = 0, rom_en = 0, access_cnt = 0, err_overlap = 0
- FSM = IDLE; synchronizers = 0; stability counter = 0

Latency from a pin change (sampled at edge E0) to oe=1 with valid data is SYNC_STAGES + STABLE_CYC + 2 edges. This is 6 clk with the default parameters.

Cycle-level sequence with the defaults:
- Edges E0–E1: W visible.
- Edge E2: count reaches 2.
- FETCH cycle follows, with rom_en=1.
- WAIT cycle follows.
- oe is high after edge E5.

Other timing rules:
- DRIVE exit: oe falls 1 edge after the changed W is visible at the synchronizer output.
- rom_en is never high for 2 consecutive cycles.
- rom_addr is stable from FETCH until the next FETCH.
- cart_data changes only on the WAIT→DRIVE edge.

## Test plan
- Basic read, s4:
  - Stimulus: ROM[0x0123]=8'hA5; addr=14'h0123, s4=1, s5=0 held.
  - Required: rom_addr=15'h0123 with rom_en pulsed once; cart_data=8'hA5 and oe=1 exactly 6 clk after the pin change.
- Window mapping, s5:
  - Stimulus: ROM[0x4123]=8'h3C; addr=14'h0123, s5=1.
  - Required: rom_addr=15'h4123, cart_data=8'h3C.
- Back-to-back reads:
  - Stimulus: address changes 0x0010→0x0011 with s4 held; ROM values 8'h11 and 8'h22.
  - Required: oe drops, re-fetches, and returns 8'h22 with no cycle showing the wrong byte with oe=1.
- Glitch rejection:
  - Stimulus: a 1-clk address glitch during SETTLE.
  - Required: the stability counter restarts, only the final address is fetched, and rom_en is pulsed once.
- Overlap:
  - Stimulus: s4=s5=1 for 3 clk, then s4 only.
  - Required: err_overlap=1 and remains 1; oe=0 during the overlap; normal read resumes afterwards.
- Counter and reset:
  - Stimulus: 5 cart_phi pulses with s4 active and 3 with no select, then assert rst_L low during DRIVE.
  - Required: access_cnt=5 before reset; oe falls combinationally with rst_L; after reset all outputs are 0 and the FSM is in IDLE.
